onchip_ram_pipelined: RTL and testbench

ONCHIP_RAM_PIPELINED -- requirements
Module: onchip_ram_pipelined

---
 rtl/onchip_ram_pipelined.sv | 184 ++++++++++++++++++
 tb/tb_onchip_ram_pipelined.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_pipelined.sv
// ---------------------------------------------------------------------------
// onchip_ram_pipelined
//
// Single-port on-chip RAM with an Avalon-MM style slave interface, an
// optional zero-fill sequence after reset and a 1- or 2-cycle read pipeline.
// The whole pipeline, including the RAM read register, is frozen while the
// clock enable is low or a reset request is pending.
//
// Ports
//   clk            sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   address        word address (ADDR_WIDTH bits)
//   byteenable     per-byte write enable (DATA_WIDTH/8 bits)
//   chipselect     slave select; read/write ignored when low
//   read, write    request strobes; both high = write only
//   writedata      write data
//   clken          clock enable; low = stall
//   reset_req      stall request; high = stall, like clken low
//   readdata       read data, valid only with readdatavalid (zero otherwise)
//   readdatavalid  one pulse per accepted read, READ_LATENCY enabled cycles later
//   waitrequest    high = request not accepted this cycle
//   init_done      high once the zero fill has completed
// ---------------------------------------------------------------------------
module onchip_ram_pipelined #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 13,
    parameter int DEPTH         = 6144,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic                      clken,
    input  logic                      reset_req,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    output logic                      init_done
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    state_t             state_reg;
    logic [IDX_W-1:0]   init_cnt_reg;

    logic en;
    logic in_run;
    logic addr_ok;
    logic req_ok;
    logic wr_accept;
    logic rd_accept;

    assign en      = clken & ~reset_req;
    assign in_run  = (state_reg == ST_RUN);
    assign addr_ok = ({1'b0, address} < DEPTH_LIM);

    // reset_n is folded in so the slave looks busy for the whole reset
    // period, even when the reset state is already RUN.
    assign waitrequest = ~reset_n | ~in_run | ~en;
    assign init_done   = reset_n & in_run;

    assign req_ok    = chipselect & ~waitrequest;
    assign wr_accept = req_ok & write;
    assign rd_accept = req_ok & read & ~write;   // write wins, read dropped

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= RESET_STATE;
            init_cnt_reg <= '0;
        end else if (state_reg == ST_INIT && en) begin
            if (init_cnt_reg == LAST_IDX) begin
                state_reg <= ST_RUN;
            end else begin
                init_cnt_reg <= init_cnt_reg + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array: one port shared by the zero fill and the bus.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [NUM_LANES-1:0]  lane_we;

    // Out-of-range addresses alias onto a truncated index; the write is
    // suppressed and the read result is masked by the registered range flag.
    assign mem_idx   = in_run ? address[IDX_W-1:0] : init_cnt_reg;
    assign mem_wdata = in_run ? writedata : '0;
    assign mem_we    = in_run ? (wr_accept & addr_ok) : en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            // The zero fill writes full words regardless of byteenable.
            assign lane_we[gi] = mem_we & (~in_run | byteenable[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_we[i]) begin
                mem[mem_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
        if (en) begin
            ram_q <= mem[mem_idx];
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Every stage advances only on enabled cycles, so a
    // stall holds in-flight reads in place and latency counts enabled
    // cycles only.
    // ------------------------------------------------------------------
    logic                  rd_vld1_reg;
    logic                  rd_ok1_reg;
    logic [DATA_WIDTH-1:0] stage1_data;
    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld1_reg <= 1'b0;
            rd_ok1_reg  <= 1'b0;
        end else if (en) begin
            rd_vld1_reg <= rd_accept;
            rd_ok1_reg  <= addr_ok;
        end
    end

    assign stage1_data = rd_ok1_reg ? ram_q : '0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rd_vld2_reg;
            logic [DATA_WIDTH-1:0] rd_data2_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_vld2_reg  <= 1'b0;
                    rd_data2_reg <= '0;
                end else if (en) begin
                    rd_vld2_reg  <= rd_vld1_reg;
                    rd_data2_reg <= stage1_data;
                end
            end

            assign out_vld  = rd_vld2_reg;
            assign out_data = rd_data2_reg;
        end else begin : g_lat1
            assign out_vld  = rd_vld1_reg;
            assign out_data = stage1_data;
        end
    endgenerate

    // A held result is only presented on an enabled cycle, which makes the
    // pulse last exactly one enabled cycle.
    assign readdatavalid = out_vld & en;
    assign readdata      = readdatavalid ? out_data : '0;

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// ---------------------------------------------------------------------------
// tb_onchip_ram_pipelined
//
// Directed bench for onchip_ram_pipelined. Two instances (READ_LATENCY 1
// and 2, DEPTH 16) share every input so each transaction checks both.
// Inputs change 1 ns after the rising edge, outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_onchip_ram_pipelined;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        clken;
    logic        reset_req;

    logic [31:0] rd1, rd2;
    logic        rdv1, rdv2;
    logic        wr1, wr2;
    logic        id1, id2;

    int n_cmp = 0;
    int n_mis = 0;

    int pulse1 = 0;
    int pulse2 = 0;
    int stall_pulses = 0;
    bit mon_on = 1'b0;
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    onchip_ram_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(13), .DEPTH(16),
        .READ_LATENCY(1), .INIT_ON_RESET(1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .readdata(rd1), .readdatavalid(rdv1),
        .waitrequest(wr1), .init_done(id1)
    );

    onchip_ram_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(13), .DEPTH(16),
        .READ_LATENCY(2), .INIT_ON_RESET(1)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .readdata(rd2), .readdatavalid(rdv2),
        .waitrequest(wr2), .init_done(id2)
    );

    // Pulse monitor
    always @(negedge clk) begin
        if (rdv1) pulse1++;
        if (rdv2) pulse2++;
        if ((rdv1 || rdv2) && !clken) stall_pulses++;
        if (mon_on && rdv1) q1.push_back(rd1);
        if (mon_on && rdv2) q2.push_back(rd2);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single write; starts and ends 1 ns after a rising edge.
    task automatic wr_word(input string tag, input logic [12:0] a, input logic [31:0] d,
                           input logic [3:0] be);
        address = a; writedata = d; byteenable = be;
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        @(negedge clk);
        check_val({tag, " wait"}, {30'd0, wr2, wr1}, 32'd0);
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    // Single read; measures the latency and data of both instances.
    task automatic rd_check(input string tag, input logic [12:0] a, input logic [31:0] exp);
        int lat1 = 0, lat2 = 0, n1 = 0, n2 = 0;
        logic [31:0] d1 = '0, d2 = '0;
        address = a; chipselect = 1'b1; read = 1'b1; write = 1'b0;
        @(negedge clk);
        check_val({tag, " wait"}, {30'd0, wr2, wr1}, 32'd0);
        step();
        chipselect = 1'b0; read = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (rdv1) begin n1++; if (lat1 == 0) begin lat1 = k; d1 = rd1; end end
            if (rdv2) begin n2++; if (lat2 == 0) begin lat2 = k; d2 = rd2; end end
            step();
        end
        check_val({tag, " lat1"}, lat1, 1);
        check_val({tag, " lat2"}, lat2, 2);
        check_val({tag, " npulse"}, n1 + n2, 2);
        check_val({tag, " data1"}, d1, exp);
        check_val({tag, " data2"}, d2, exp);
    endtask

    // Runs the zero fill to completion; stall_at < 0 means no stall,
    // otherwise clken is held low for cycles stall_at and stall_at+1.
    task automatic wait_init(input string tag, input int stall_at, input int exp_cyc);
        int cyc = 0, en_cyc = 0, wr_low = 0;
        bit done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            clken = !(c == stall_at || c == stall_at + 1);
            @(negedge clk);
            if (id1 && id2) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (clken) en_cyc++;
                if (!wr1 || !wr2) wr_low++;
            end
            step();
        end
        clken = 1'b1;
        check_val({tag, " done"}, {31'd0, done}, 32'd1);
        check_val({tag, " en_cycles"}, en_cyc, 16);
        check_val({tag, " cycles"}, cyc, exp_cyc);
        check_val({tag, " wait_low"}, wr_low, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " rdv"}, {30'd0, rdv2, rdv1}, 32'd0);
        check_val({tag, " rd1"}, rd1, 32'd0);
        check_val({tag, " rd2"}, rd2, 32'd0);
        check_val({tag, " init_done"}, {30'd0, id2, id1}, 32'd0);
        check_val({tag, " waitreq"}, {30'd0, wr2, wr1}, 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p1, p2;
        reset_n = 1'b0; address = '0; byteenable = '0; chipselect = 1'b0;
        read = 1'b0; write = 1'b0; writedata = '0; clken = 1'b1; reset_req = 1'b0;

        // Reset state
        repeat (3) step();
        check_reset_outputs("reset");

        // Zero fill with a two-cycle stall
        reset_n = 1'b1;
        wait_init("init", 3, 18);

        // All words zero after the fill
        for (int i = 0; i < 16; i++) begin
            rd_check($sformatf("zero[%0d]", i), 13'(i), 32'h0);
        end

        // Partial byte writes, read immediately afterwards
        wr_word("wr5_a", 13'd5, 32'hDEADBEEF, 4'b0101);
        rd_check("rd5_a", 13'd5, 32'h00AD00EF);
        wr_word("wr5_b", 13'd5, 32'h11223344, 4'b1010);
        rd_check("rd5_b", 13'd5, 32'h11AD33EF);

        // Read and write together: write wins, no readdatavalid
        p1 = pulse1; p2 = pulse2;
        address = 13'd3; writedata = 32'h12345678; byteenable = 4'b1111;
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        step();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        repeat (4) step();
        check_val("rw3 no_valid", (pulse1 - p1) + (pulse2 - p2), 0);
        rd_check("rd3", 13'd3, 32'h12345678);

        // Out-of-range accesses
        wr_word("wr4", 13'd4, 32'hA5A5A5A5, 4'b1111);
        rd_check("rd20", 13'd20, 32'h0);
        wr_word("wr20", 13'd20, 32'hFFFFFFFF, 4'b1111);
        rd_check("rd4", 13'd4, 32'hA5A5A5A5);

        // Burst of reads 0..7 with a three-cycle clken stall mid-burst
        for (int i = 0; i < 8; i++) begin
            wr_word($sformatf("fill[%0d]", i), 13'(i), 32'h100 + 32'(i), 4'b1111);
        end
        stall_pulses = 0;
        q1.delete(); q2.delete();
        mon_on = 1'b1;
        chipselect = 1'b1; read = 1'b1; write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address = 13'(i);
            if (i == 4) begin
                clken = 1'b0;
                repeat (3) step();
                clken = 1'b1;
            end
            step();
        end
        chipselect = 1'b0; read = 1'b0;
        repeat (5) step();
        mon_on = 1'b0;
        check_val("burst n1", q1.size(), 8);
        check_val("burst n2", q2.size(), 8);
        check_val("burst stall_pulses", stall_pulses, 0);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("burst1[%0d]", i), (i < q1.size()) ? q1[i] : 32'hXXXXXXXX,
                      32'h100 + 32'(i));
            check_val($sformatf("burst2[%0d]", i), (i < q2.size()) ? q2[i] : 32'hXXXXXXXX,
                      32'h100 + 32'(i));
        end

        // Reset with a read in flight
        address = 13'd6; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        check_val("flight wait", {30'd0, wr2, wr1}, 32'd0);
        step();
        chipselect = 1'b0; read = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("flight_rst");
        p1 = pulse1; p2 = pulse2;
        step();
        step();
        reset_n = 1'b1;

        // Reset again while writing zero-fill word 7
        repeat (7) step();
        check_val("mid_init init_done", {30'd0, id2, id1}, 32'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_init_rst");
        step();
        reset_n = 1'b1;
        wait_init("reinit", -10, 16);
        check_val("reinit no_valid", (pulse1 - p1) + (pulse2 - p2), 0);

        rd_check("post_rd3", 13'd3, 32'h0);
        rd_check("post_rd5", 13'd5, 32'h0);
        rd_check("post_rd7", 13'd7, 32'h0);
        rd_check("post_rd4", 13'd4, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
